el2_trace_buf: RTL and testbench

Retired-instruction trace capture buffer sitting directly downstream of the core's per-cycle trace output (the `el2_trace_pkt_t` stream driven at commit). Each cycle with a valid trace packet, the packet is pushed into a small FIFO and drained to an external trace sink over a valid/ready handshake. When the sink stalls and the FIFO is full, packets are dropped. Drops are counted, and the next accepted packet is tagged as following a gap.

---
 rtl/el2_trace_buf_pkg.sv | 22 ++
 rtl/el2_trace_buf_fifo.sv | 47 ++++
 rtl/el2_trace_buf.sv | 82 ++++++++
 tb/tb_el2_trace_buf.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/el2_trace_buf_pkg.sv
// Types shared by the retired-instruction trace capture buffer.
package el2_trace_buf_pkg;

    typedef struct packed {
        logic [31:0] trace_rv_i_insn_ip;
        logic [31:0] trace_rv_i_address_ip;
        logic        trace_rv_i_valid_ip;
        logic        trace_rv_i_exception_ip;
        logic [4:0]  trace_rv_i_ecause_ip;
        logic        trace_rv_i_interrupt_ip;
        logic [31:0] trace_rv_i_tval_ip;
    } el2_trace_pkt_t;

    // One buffered packet; gap marks the first packet accepted after lost packets.
    typedef struct packed {
        logic           gap;
        el2_trace_pkt_t pkt;
    } el2_trace_buf_entry_t;

    localparam int unsigned TRACE_ENTRY_W = $bits(el2_trace_buf_entry_t);

endpackage

// File: rtl/el2_trace_buf_fifo.sv
// Generic FIFO with an explicit occupancy counter; full/empty are decoded from level only.
module el2_trace_buf_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_l,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            level <= level + LVL_W'(push) - LVL_W'(pop);
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/el2_trace_buf.sv
// Trace capture buffer: FIFO between commit trace and an external sink, with drop counting and gap tagging.
module el2_trace_buf
    import el2_trace_buf_pkg::*;
#(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned DROP_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_l,
    input  logic                   trace_en,
    input  el2_trace_pkt_t         trace_pkt_i,
    input  logic                   flush,
    input  logic                   drop_cnt_clr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output el2_trace_buf_entry_t   out_entry,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   overflow,
    output logic [DROP_CNT_W-1:0]  drop_cnt
);

    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic                     push_req;
    logic                     pop;
    logic                     accept;
    logic                     drop;
    logic                     gap_pending;
    el2_trace_buf_entry_t     wentry;
    logic [TRACE_ENTRY_W-1:0] rdata;

    assign out_valid = (level != '0);
    assign full      = (level == LVL_W'(DEPTH));
    assign push_req  = trace_en & trace_pkt_i.trace_rv_i_valid_ip & ~flush;
    assign pop       = out_valid & out_ready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign accept    = push_req & (~full | pop);
    assign drop      = push_req & full & ~pop;

    assign wentry.gap = gap_pending;
    assign wentry.pkt = trace_pkt_i;
    assign out_entry  = el2_trace_buf_entry_t'(rdata);

    el2_trace_buf_fifo #(
        .WIDTH (TRACE_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_l (rst_l),
        .push  (accept),
        .pop   (pop),
        .flush (flush),
        .wdata (wentry),
        .rdata (rdata),
        .level (level)
    );

    // Flushing buffered packets also loses trace, so the next packet is tagged as a gap.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            gap_pending <= 1'b0;
            overflow    <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            overflow <= drop;
            if (flush && out_valid) begin
                gap_pending <= 1'b1;
            end else if (drop) begin
                gap_pending <= 1'b1;
            end else if (accept) begin
                gap_pending <= 1'b0;
            end
            if (drop_cnt_clr) begin
                drop_cnt <= drop ? DROP_CNT_W'(1) : '0;
            end else if (drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + DROP_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_el2_trace_buf.sv
// Directed self-checking bench for el2_trace_buf (DEPTH=8, 2-bit drop counter).
module tb_el2_trace_buf;
    import el2_trace_buf_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = 2;

    logic                 clk = 1'b0;
    logic                 rst_l;
    logic                 trace_en;
    logic                 flush;
    logic                 drop_cnt_clr;
    logic                 out_ready;
    logic                 out_valid;
    logic                 full;
    logic                 overflow;
    el2_trace_pkt_t       trace_pkt_i;
    el2_trace_buf_entry_t out_entry;
    logic [3:0]           level;
    logic [CW-1:0]        drop_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    el2_trace_buf #(.DEPTH(DEPTH), .DROP_CNT_W(CW)) dut (
        .clk          (clk),
        .rst_l        (rst_l),
        .trace_en     (trace_en),
        .trace_pkt_i  (trace_pkt_i),
        .flush        (flush),
        .drop_cnt_clr (drop_cnt_clr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_entry    (out_entry),
        .level        (level),
        .full         (full),
        .overflow     (overflow),
        .drop_cnt     (drop_cnt)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic el2_trace_pkt_t mkpkt(input logic [31:0] pc);
        el2_trace_pkt_t p;
        p = '0;
        p.trace_rv_i_valid_ip   = 1'b1;
        p.trace_rv_i_address_ip = pc;
        p.trace_rv_i_insn_ip    = pc ^ 32'h0013_0013;
        p.trace_rv_i_tval_ip    = ~pc;
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic v, input logic [31:0] pc);
        trace_pkt_i = mkpkt(pc);
        trace_pkt_i.trace_rv_i_valid_ip = v;
    endtask

    task automatic check_head(input string tag, input logic gap, input logic [31:0] pc);
        el2_trace_buf_entry_t e;
        e.gap = gap;
        e.pkt = mkpkt(pc);
        check({tag, "_valid"}, 128'(out_valid), 128'(1));
        check(tag, 128'(out_entry), 128'(e));
    endtask

    logic [31:0] q[$];

    initial begin
        rst_l        = 1'b0;
        trace_en     = 1'b1;
        flush        = 1'b0;
        drop_cnt_clr = 1'b0;
        out_ready    = 1'b0;
        trace_pkt_i  = '0;
        tick();
        tick();
        check("rst_valid", 128'(out_valid), 128'(0));
        check("rst_level", 128'(level), 128'(0));
        check("rst_full", 128'(full), 128'(0));
        check("rst_ovf", 128'(overflow), 128'(0));
        check("rst_dcnt", 128'(drop_cnt), 128'(0));
        rst_l = 1'b1;
        tick();

        // In-order flow-through, one cycle latency
        out_ready = 1'b1;
        send(1'b1, 32'h100);
        tick();
        check_head("t1_p0", 1'b0, 32'h100);
        send(1'b1, 32'h104);
        tick();
        check_head("t1_p1", 1'b0, 32'h104);
        send(1'b1, 32'h108);
        tick();
        check_head("t1_p2", 1'b0, 32'h108);
        send(1'b0, 32'h0);
        tick();
        check("t1_empty", 128'(out_valid), 128'(0));
        check("t1_dcnt", 128'(drop_cnt), 128'(0));

        // Stall sink: 11 packets into 8 entries, three dropped
        out_ready = 1'b0;
        for (int i = 0; i < 11; i++) begin
            send(1'b1, 32'h200 + 32'(4 * i));
            tick();
            check("t2_level", 128'(level), 128'((i + 1 > 8) ? 8 : i + 1));
            check("t2_ovf", 128'(overflow), 128'(i >= 8));
        end
        check("t2_full", 128'(full), 128'(1));
        check("t2_dcnt", 128'(drop_cnt), 128'(3));
        check_head("t2_h0", 1'b0, 32'h200);
        out_ready = 1'b1;
        send(1'b1, 32'h300);
        tick();
        check("t2_ovf_end", 128'(overflow), 128'(0));
        check("t2_level_pp", 128'(level), 128'(8));
        send(1'b0, 32'h0);
        for (int k = 1; k < 8; k++) begin
            check_head("t2_drain", 1'b0, 32'h200 + 32'(4 * k));
            tick();
        end
        check_head("t2_gap", 1'b1, 32'h300);
        tick();
        check("t2_empty", 128'(out_valid), 128'(0));

        // Full FIFO streaming across pointer wrap
        out_ready = 1'b0;
        q.delete();
        for (int i = 0; i < 8; i++) begin
            send(1'b1, 32'h400 + 32'(4 * i));
            q.push_back(32'h400 + 32'(4 * i));
            tick();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 24; k++) begin
            check_head("t3_stream", 1'b0, q[0]);
            send(1'b1, 32'h500 + 32'(4 * k));
            tick();
            void'(q.pop_front());
            q.push_back(32'h500 + 32'(4 * k));
            check("t3_level", 128'(level), 128'(8));
            check("t3_ovf", 128'(overflow), 128'(0));
        end
        send(1'b0, 32'h0);
        for (int k = 0; k < 8; k++) begin
            check_head("t3_drain", 1'b0, q.pop_front());
            tick();
        end
        check("t3_empty", 128'(out_valid), 128'(0));
        check("t3_dcnt", 128'(drop_cnt), 128'(3));

        // Capture disabled
        trace_en  = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(1'b1, 32'h5f0 + 32'(4 * i));
            tick();
        end
        check("t4_level", 128'(level), 128'(0));
        check("t4_valid", 128'(out_valid), 128'(0));
        check("t4_dcnt", 128'(drop_cnt), 128'(3));
        trace_en = 1'b1;

        // Flush with buffered entries tags the next packet
        for (int i = 0; i < 5; i++) begin
            send(1'b1, 32'h600 + 32'(4 * i));
            tick();
        end
        check("t5_level5", 128'(level), 128'(5));
        send(1'b0, 32'h0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t5_valid", 128'(out_valid), 128'(0));
        check("t5_level", 128'(level), 128'(0));
        send(1'b1, 32'h700);
        tick();
        check_head("t5_gap", 1'b1, 32'h700);
        out_ready = 1'b1;
        send(1'b0, 32'h0);
        tick();
        check("t5_empty", 128'(out_valid), 128'(0));

        // Saturation, clear-with-drop, then async reset mid-stream
        drop_cnt_clr = 1'b1;
        tick();
        drop_cnt_clr = 1'b0;
        check("t6_clr", 128'(drop_cnt), 128'(0));
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send(1'b1, 32'h800 + 32'(4 * i));
            tick();
        end
        for (int d = 1; d <= 5; d++) begin
            send(1'b1, 32'h900 + 32'(4 * d));
            tick();
            check("t6_sat", 128'(drop_cnt), 128'((d > 3) ? 3 : d));
            check("t6_ovf", 128'(overflow), 128'(1));
        end
        drop_cnt_clr = 1'b1;
        send(1'b1, 32'h9f0);
        tick();
        drop_cnt_clr = 1'b0;
        check("t6_clr_drop", 128'(drop_cnt), 128'(1));
        rst_l = 1'b0;
        #1;
        check("t6_rst_valid", 128'(out_valid), 128'(0));
        check("t6_rst_level", 128'(level), 128'(0));
        check("t6_rst_full", 128'(full), 128'(0));
        check("t6_rst_ovf", 128'(overflow), 128'(0));
        check("t6_rst_dcnt", 128'(drop_cnt), 128'(0));
        tick();
        tick();
        rst_l = 1'b1;
        send(1'b1, 32'hb00);
        tick();
        check_head("t6_post", 1'b0, 32'hb00);
        check("t6_post_level", 128'(level), 128'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
